// File: rtl/sram_bus_arbiter_if.sv
// rtl/sram_bus_arbiter_if.sv - SRAM-like request/response bus bundle
// A requester drives the master side; the side that accepts requests uses the slave side.
interface sram_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [3:0]        wstrb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - shares one SRAM-like bus between inst and data requesters
// Optional round-robin arbitration via SRAM_ARB_RR_EN (default: data has fixed priority).
module sram_bus_arbiter #(
  parameter int OUTST_DEPTH = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  sram_bus_arbiter_if.slave        inst_if,
  sram_bus_arbiter_if.slave        data_if,
  sram_bus_arbiter_if.master       bus_if,
  output logic                     proto_err
);
  localparam int PTR_W = $clog2(OUTST_DEPTH);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [OUTST_DEPTH-1:0] r_tag;
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [PTR_W:0]       r_count;
  logic                 r_proto_err;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_push_tag;
  logic                 w_pop;
  logic                 w_head_tag;
  logic                 w_pick_data;

  logic                 w_req;
  logic                 w_wr;
  logic [1:0]           w_size;
  logic [3:0]           w_wstrb;
  logic [ADDR_W-1:0]    w_addr;
  logic [DATA_W-1:0]    w_wdata;
  logic                 w_inst_aok;
  logic                 w_data_aok;
  logic                 w_unused_inst;

  // The instruction side is read-only, so its write fields are never forwarded.
  assign w_unused_inst = ^{inst_if.wr, inst_if.wstrb, inst_if.wdata};

  assign w_full     = (r_count == (PTR_W+1)'(OUTST_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push     = (r_state != IDLE) && bus_if.addr_ok;
  assign w_push_tag = (r_state == GNT_D);
  assign w_pop      = bus_if.data_ok && !w_empty;
  assign w_head_tag = r_tag[r_head];

`ifdef SRAM_ARB_RR_EN
  logic r_rr_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_data <= 1'b1;
    end else if (w_push) begin
      r_rr_data <= !w_push_tag;
    end
  end

  assign w_pick_data = data_if.req && (r_rr_data || !inst_if.req);
`else
  assign w_pick_data = data_if.req;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // full uses the registered count, so a same-cycle pop never opens a grant.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (!w_full) begin
          if (w_pick_data) begin
            w_state_nxt = GNT_D;
          end else if (inst_if.req) begin
            w_state_nxt = GNT_I;
          end
        end
      end
      GNT_I, GNT_D: begin
        if (bus_if.addr_ok) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_req      = 1'b0;
    w_wr       = 1'b0;
    w_size     = 2'd0;
    w_wstrb    = 4'd0;
    w_addr     = '0;
    w_wdata    = '0;
    w_inst_aok = 1'b0;
    w_data_aok = 1'b0;
    case (r_state)
      GNT_I: begin
        w_req      = 1'b1;
        w_size     = inst_if.size;
        w_addr     = inst_if.addr;
        w_inst_aok = bus_if.addr_ok;
      end
      GNT_D: begin
        w_req      = 1'b1;
        w_wr       = data_if.wr;
        w_size     = data_if.size;
        w_wstrb    = data_if.wstrb;
        w_addr     = data_if.addr;
        w_wdata    = data_if.wdata;
        w_data_aok = bus_if.addr_ok;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag       <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_tag[r_tail] <= w_push_tag;
        r_tail        <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
      if (bus_if.data_ok && w_empty) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign bus_if.req     = w_req;
  assign bus_if.wr      = w_wr;
  assign bus_if.size    = w_size;
  assign bus_if.wstrb   = w_wstrb;
  assign bus_if.addr    = w_addr;
  assign bus_if.wdata   = w_wdata;

  assign inst_if.addr_ok = w_inst_aok;
  assign data_if.addr_ok = w_data_aok;
  assign inst_if.data_ok = w_pop && !w_head_tag;
  assign data_if.data_ok = w_pop && w_head_tag;
  assign inst_if.rdata   = bus_if.rdata;
  assign data_if.rdata   = bus_if.rdata;

  assign proto_err = r_proto_err;
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb/tb_sram_bus_arbiter.sv - self-checking bench for sram_bus_arbiter
// Vector table plus hand sequences; a tag queue checks response routing.
module tb_sram_bus_arbiter;
  localparam logic [31:0] IADDR  = 32'h1c000000;
  localparam logic [31:0] DADDR  = 32'h00001000;
  localparam logic [31:0] DWDATA = 32'h12345678;
  localparam logic [3:0]  DWSTRB = 4'b1100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic proto_err;

  always #5 clk = ~clk;

  sram_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_if ();
  sram_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_if ();
  sram_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  sram_bus_arbiter #(.OUTST_DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .inst_if   (inst_if),
    .data_if   (data_if),
    .bus_if    (bus_if),
    .proto_err (proto_err)
  );

  // g / rsp: 0 = none, 1 = inst, 2 = data
  typedef struct {
    logic        ireq;
    logic        dreq;
    logic        dwr;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    int          g;
    int          rsp;
    logic        perr;
  } vec_t;

  int   n_pass  = 0;
  int   n_total = 0;
  bit   sb_q[$];
  vec_t tbl[$];
  int   gs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic ireq, input logic dreq, input logic dwr,
                              input logic aok, input logic dok, input logic [31:0] rdata,
                              input int g, input int rsp);
    vec_t v;
    v.ireq = ireq; v.dreq = dreq; v.dwr = dwr; v.aok = aok; v.dok = dok;
    v.rdata = rdata; v.g = g; v.rsp = rsp; v.perr = 1'b0;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    bit t;
    inst_if.req    = v.ireq;
    data_if.req    = v.dreq;
    data_if.wr     = v.dwr;
    bus_if.addr_ok = v.aok;
    bus_if.data_ok = v.dok;
    bus_if.rdata   = v.rdata;
    if (v.g == 1 && v.aok) sb_q.push_back(1'b0);
    if (v.g == 2 && v.aok) sb_q.push_back(1'b1);
    @(negedge clk);
    check({tag, " bus_req"},   bus_if.req,   v.g != 0);
    check({tag, " bus_addr"},  bus_if.addr,  v.g == 2 ? DADDR : (v.g == 1 ? IADDR : 32'h0));
    check({tag, " bus_wr"},    bus_if.wr,    v.g == 2 ? v.dwr : 1'b0);
    check({tag, " bus_size"},  bus_if.size,  v.g != 0 ? 2'd2 : 2'd0);
    check({tag, " bus_wstrb"}, bus_if.wstrb, v.g == 2 ? DWSTRB : 4'h0);
    check({tag, " bus_wdata"}, bus_if.wdata, v.g == 2 ? DWDATA : 32'h0);
    check({tag, " inst_addr_ok"}, inst_if.addr_ok, v.g == 1 && v.aok);
    check({tag, " data_addr_ok"}, data_if.addr_ok, v.g == 2 && v.aok);
    check({tag, " inst_data_ok"}, inst_if.data_ok, v.rsp == 1);
    check({tag, " data_data_ok"}, data_if.data_ok, v.rsp == 2);
    check({tag, " proto_err"}, proto_err, v.perr);
    if (inst_if.data_ok || data_if.data_ok) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL %s scoreboard: response with no request outstanding", tag);
      end else begin
        t = sb_q.pop_front();
        check({tag, " sb_route"}, {31'b0, data_if.data_ok}, {31'b0, t});
        check({tag, " sb_rdata"}, t ? data_if.rdata : inst_if.rdata, v.rdata);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    inst_if.req = 1'b1; data_if.req = 1'b1; data_if.wr = 1'b0;
    bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b0; bus_if.rdata = 32'h0;
    reset = 1'b1;
    sb_q.delete();
    #1;
    check("rst bus_req", bus_if.req, 1'b0);
    check("rst bus_addr", bus_if.addr, 32'h0);
    check("rst addr_ok", {inst_if.addr_ok, data_if.addr_ok}, 2'b00);
    check("rst data_ok", {inst_if.data_ok, data_if.data_ok}, 2'b00);
    check("rst rdata", inst_if.rdata | data_if.rdata, 32'h0);
    check("rst proto_err", proto_err, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    inst_if.req = 1'b0; data_if.req = 1'b0;
  endtask

  initial begin
    vec_t v;
    inst_if.req = 1'b0; inst_if.wr = 1'b0; inst_if.size = 2'd2; inst_if.wstrb = 4'h0;
    inst_if.addr = IADDR; inst_if.wdata = 32'h0;
    data_if.req = 1'b0; data_if.wr = 1'b0; data_if.size = 2'd2; data_if.wstrb = DWSTRB;
    data_if.addr = DADDR; data_if.wdata = DWDATA;
    bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b0; bus_if.rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Response with nothing outstanding: dropped, proto_err sticks until reset
    run_vec(mk(0, 0, 0, 0, 1, 32'hDEAD, 0, 0), "perr0");
    v = mk(0, 0, 0, 0, 0, 32'h0, 0, 0);
    v.perr = 1'b1;
    run_vec(v, "perr1");
    run_vec(v, "perr2");
    do_reset();

    tbl.push_back(mk(0, 0, 0, 1, 0, 32'h0,      0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 32'h0,      0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 32'h0,      2, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 32'h0,      2, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, 32'h0,      2, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,      0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 32'h0,      1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'hBBBB,   0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'hAAAA,   0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,      0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 32'h0,      1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,      0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 32'h0,      2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'hAAAA,   0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'hBBBB,   0, 2));
    tbl.push_back(mk(0, 1, 1, 0, 0, 32'h0,      0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 32'h0,      2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0,      0, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,      0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 32'h0,      1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,      0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 32'h55,     1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h66,     0, 1));
    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Fill the tag FIFO, then a pop alongside a blocked grant
    for (int k = 0; k < 4; k++) begin
      run_vec(mk(1, 0, 0, 0, 0, 32'h0, 0, 0), $sformatf("fill%0d_idle", k));
      run_vec(mk(1, 0, 0, 1, 0, 32'h0, 1, 0), $sformatf("fill%0d_gnt", k));
    end
    run_vec(mk(1, 1, 0, 0, 0, 32'h0,  0, 0), "full_blk0");
    run_vec(mk(1, 1, 0, 0, 0, 32'h0,  0, 0), "full_blk1");
    run_vec(mk(1, 1, 0, 0, 1, 32'h11, 0, 1), "full_pop_blk");
    run_vec(mk(1, 0, 0, 0, 0, 32'h0,  0, 0), "full_resume_idle");
    run_vec(mk(1, 0, 0, 1, 1, 32'h22, 1, 1), "full_resume_gnt");
    for (int k = 0; k < 3; k++)
      run_vec(mk(0, 0, 0, 0, 1, 32'h33 + k, 0, 1), $sformatf("full_drain%0d", k));
    check("full sb_empty", sb_q.size(), 32'd0);

    // Both requesting continuously with addr_ok always high
    do_reset();
    for (int k = 0; k < 4; k++) begin
`ifdef SRAM_ARB_RR_EN
      gs[k] = (k % 2 == 0) ? 2 : 1;
`else
      gs[k] = 2;
`endif
      run_vec(mk(1, 1, 0, 1, 0, 32'h0, 0, 0), $sformatf("both%0d_idle", k));
      run_vec(mk(1, 1, 0, 1, 0, 32'h0, gs[k], 0), $sformatf("both%0d_gnt", k));
    end
    for (int k = 0; k < 4; k++)
      run_vec(mk(0, 0, 0, 0, 1, 32'h100 + k, 0, gs[k]), $sformatf("both_rsp%0d", k));
    check("both sb_empty", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
